// File: rtl/band_level_meter.sv
// band_level_meter
//   Per-band level meter placed after one band-pass FIR. The signed 18-bit
//   filtered stream is rectified and averaged over a window of 2^WIN_LOG2
//   samples. The window mean then drives an 8-bit display level that holds
//   its peak for a while and then decays linearly.
//
//   Parameters:
//     WIN_LOG2     - log2 of the window length (2..16)
//     HOLD_WINDOWS - number of windows a peak is held before decay (0..255)
//     DECAY_STEP   - amount subtracted from level per decaying window (1..255)
//
//   Ports:
//     clock       in   system clock
//     reset       in   asynchronous active-low reset
//     ready       in   one-cycle sample strobe
//     band_in     in   signed 18-bit band sample, valid when ready=1
//     level       out  held/decayed band level
//     level_valid out  one-cycle pulse when level/clip update
//     clip        out  last window contained a full-scale sample
//
//   Optional build macro:
//     BAND_METER_LOG_EN - pseudo-logarithmic candidate level, one extra
//                         pipeline stage in the evaluation path.

module band_level_meter #(
  parameter int WIN_LOG2     = 10,
  parameter int HOLD_WINDOWS = 8,
  parameter int DECAY_STEP   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ready,
  input  logic [17:0] band_in,
  output logic [7:0]  level,
  output logic        level_valid,
  output logic        clip
);

  localparam int ACC_W = 17 + WIN_LOG2;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_AVG   = 2'd1,
    ST_PEAK  = 2'd2
  } state_t;

  logic [16:0]         abs_s;
  logic                full_scale_s;
  logic                window_end_s;
  logic [ACC_W-1:0]    acc_sum_s;
  logic [ACC_W-1:0]    acc_r;
  logic [WIN_LOG2-1:0] cnt_r;
  logic                clip_acc_r;
  logic [ACC_W-1:0]    snap_r;
  logic                clip_snap_r;
  state_t              state_r;
  logic [7:0]          cand_r;
  logic [7:0]          hold_cnt_r;
  logic [7:0]          level_r;
  logic                level_valid_r;
  logic                clip_r;
  logic [7:0]          decayed_s;
  logic [7:0]          next_level_s;
  logic [7:0]          next_hold_s;

`ifdef BAND_METER_LOG_EN
  logic [16:0]         mean_r;
  logic                avg_stage_r;

  // Pseudo-log mapping: upper nibble is the MSB index, lower nibble the
  // four bits just below the MSB (a left shift zero-fills when p < 4).
  function automatic logic [7:0] log_cand(input logic [16:0] mean);
    logic [4:0]  p;
    logic [16:0] norm;
    p = 5'd0;
    for (int i = 0; i < 17; i++) begin
      if (mean[i]) begin
        p = 5'(i);
      end
    end
    norm = mean << (5'd16 - p);
    if (mean == 17'd0) begin
      return 8'd0;
    end else if (p == 5'd16) begin
      return 8'hFF;
    end else begin
      return {p[3:0], norm[15:12]};
    end
  endfunction
`endif

  // Rectifier: two's-complement magnitude, most negative code saturates.
  always_comb begin
    abs_s = band_in[16:0];
    if (band_in[17]) begin
      if (band_in[16:0] == 17'd0) begin
        abs_s = 17'h1FFFF;
      end else begin
        abs_s = ~band_in[16:0] + 17'd1;
      end
    end else begin
      abs_s = band_in[16:0];
    end
  end

  assign full_scale_s = (band_in == 18'h20000) || (band_in == 18'h1FFFF);
  assign acc_sum_s    = acc_r + ACC_W'(abs_s);
  assign window_end_s = ready & (&cnt_r);

  // Peak-hold / decay decision for the current candidate, no unsigned wrap.
  always_comb begin
    next_level_s = level_r;
    next_hold_s  = hold_cnt_r;
    decayed_s    = 8'd0;
    if (cand_r >= level_r) begin
      next_level_s = cand_r;
      next_hold_s  = 8'(HOLD_WINDOWS);
    end else if (hold_cnt_r != 8'd0) begin
      next_hold_s  = hold_cnt_r - 8'd1;
    end else begin
      if (level_r > 8'(DECAY_STEP)) begin
        decayed_s = level_r - 8'(DECAY_STEP);
      end else begin
        decayed_s = 8'd0;
      end
      if (decayed_s > cand_r) begin
        next_level_s = decayed_s;
      end else begin
        next_level_s = cand_r;
      end
    end
  end

  // Sample path: accumulate rectified samples and snapshot at window end.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_r       <= '0;
      cnt_r       <= '0;
      clip_acc_r  <= 1'b0;
      snap_r      <= '0;
      clip_snap_r <= 1'b0;
    end else if (ready) begin
      cnt_r <= cnt_r + WIN_LOG2'(1);
      if (window_end_s) begin
        // Last sample of the window goes straight into the snapshot so
        // the next window starts clean without dropping a sample.
        snap_r      <= acc_sum_s;
        clip_snap_r <= clip_acc_r | full_scale_s;
        acc_r       <= '0;
        clip_acc_r  <= 1'b0;
      end else begin
        acc_r      <= acc_sum_s;
        clip_acc_r <= clip_acc_r | full_scale_s;
      end
    end
  end

  // Evaluation FSM: mean -> candidate -> peak/hold/decay, registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_ACCUM;
      cand_r        <= 8'd0;
      hold_cnt_r    <= 8'd0;
      level_r       <= 8'd0;
      level_valid_r <= 1'b0;
      clip_r        <= 1'b0;
`ifdef BAND_METER_LOG_EN
      mean_r        <= 17'd0;
      avg_stage_r   <= 1'b0;
`endif
    end else begin
      level_valid_r <= 1'b0;
      case (state_r)
        ST_ACCUM: begin
          if (window_end_s) begin
            state_r <= ST_AVG;
          end
        end
        ST_AVG: begin
`ifdef BAND_METER_LOG_EN
          if (!avg_stage_r) begin
            mean_r      <= snap_r[ACC_W-1 -: 17];
            avg_stage_r <= 1'b1;
          end else begin
            cand_r      <= log_cand(mean_r);
            avg_stage_r <= 1'b0;
            state_r     <= ST_PEAK;
          end
`else
          // mean = snap >> WIN_LOG2; its top byte is the linear candidate.
          cand_r  <= snap_r[ACC_W-1 -: 8];
          state_r <= ST_PEAK;
`endif
        end
        ST_PEAK: begin
          level_r       <= next_level_s;
          hold_cnt_r    <= next_hold_s;
          clip_r        <= clip_snap_r;
          level_valid_r <= 1'b1;
          state_r       <= ST_ACCUM;
        end
        default: begin
          state_r <= ST_ACCUM;
        end
      endcase
    end
  end

  assign level       = level_r;
  assign level_valid = level_valid_r;
  assign clip        = clip_r;

endmodule
